// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared types, funct3 encodings and small decode helpers for the MA-stage
//   load/store alignment sequencer (lsu_align_seq) and its load-extract
//   datapath (lsu_load_extract).
//
//   Contents:
//     lsu_state_e    sequencer states
//     F3_*           RV32I load/store funct3 encodings
//     mem_cmd_t      registered memory-port command (everything but address)
//     access_bytes   access size in bytes for a funct3
//     is_misaligned  natural-alignment test for an access
//     spans_words    true when an access touches two aligned words
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LD_LO = 3'd1,
      S_LD_HI = 3'd2,
      S_ST    = 3'd3,
      S_RESP  = 3'd4
   } lsu_state_e;

   // Load encodings
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // Store encodings
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef struct packed {
      logic        en;
      logic        wren;
      logic        rden;
      logic [2:0]  funct3;
      logic [31:0] wdata;
   } mem_cmd_t;

   // Halfword loads/stores share funct3[1:0]=01, words use 10; everything
   // else (including encodings rejected later by decode) counts as a byte.
   function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
      case (funct3)
         F3_LH, F3_LHU: access_bytes = 3'd2;
         F3_LW:         access_bytes = 3'd4;
         default:       access_bytes = 3'd1;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] offset,
                                          input logic [2:0] funct3);
      case (funct3)
         F3_LH, F3_LHU: is_misaligned = offset[0];
         F3_LW:         is_misaligned = (offset != 2'b00);
         default:       is_misaligned = 1'b0;
      endcase
   endfunction

   // A misaligned half at offset 1 stays inside one word; only accesses
   // whose last byte falls past byte 3 need a second word read.
   function automatic logic spans_words(input logic [1:0] offset,
                                        input logic [2:0] funct3);
      spans_words = (({1'b0, offset} + access_bytes(funct3)) > 3'd4);
   endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// -----------------------------------------------------------------------------
// lsu_load_extract
//   Combinational load data merge. Concatenates the high and low aligned
//   words into a 64-bit window, shifts it right by the byte offset and
//   sign- or zero-extends the selected byte/halfword/word.
//
//   Ports:
//     lo_i      [31:0]  word read at (addr & ~3)
//     hi_i      [31:0]  word read at (addr & ~3) + 4 (ignored unless spanning)
//     offset_i  [1:0]   addr[1:0]
//     funct3_i  [2:0]   load funct3 (LB/LH/LW/LBU/LHU)
//     result_o  [31:0]  extended load result
// -----------------------------------------------------------------------------
module lsu_load_extract
   import lsu_pkg::*;
(
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [63:0] pair;
   logic [31:0] window;

   assign pair   = {hi_i, lo_i};
   assign window = 32'(pair >> {offset_i, 3'b000});

   // NOTE: every output of a combinational block gets a default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      result_o = window;
      case (funct3_i)
         F3_LB:   result_o = {{24{window[7]}},  window[7:0]};
         F3_LH:   result_o = {{16{window[15]}}, window[15:0]};
         F3_LBU:  result_o = {24'h000000, window[7:0]};
         F3_LHU:  result_o = {16'h0000,   window[15:0]};
         default: result_o = window;
      endcase
   end

endmodule

// File: rtl/lsu_align_seq.sv
// -----------------------------------------------------------------------------
// lsu_align_seq
//   MA-stage sequencer in front of the data memory. Takes one load/store at a
//   time, splits misaligned accesses (loads -> up to two aligned word reads
//   merged by lsu_load_extract, stores -> consecutive byte stores) and returns
//   a one-cycle response pulse with load data or an error flag.
//
//   Parameters:
//     MISALIGN_EN  1 = split misaligned accesses, 0 = reject them as errors
//     ADDR_W       byte address width (word+1 address wraps modulo 2^ADDR_W)
//
//   Ports:
//     i_clk, i_rst                 clock, asynchronous active-high reset
//     i_req_valid / o_req_ready    request handshake (ready only in IDLE)
//     i_req_addr/wren/rden/funct3/wdata   request fields, registered on accept
//     o_mem_en/addr/wren/rden/funct3/wdata  memory port, zero when idle
//     i_mem_rdata                  combinational read data for the current cycle
//     o_rsp_valid/err/rdata        completion pulse, error flag, load result
// -----------------------------------------------------------------------------
module lsu_align_seq
   import lsu_pkg::*;
#(
   parameter bit          MISALIGN_EN = 1'b1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic              i_req_wren,
   input  logic              i_req_rden,
   input  logic [2:0]        i_req_funct3,
   input  logic [31:0]       i_req_wdata,
   output logic              o_mem_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_wren,
   output logic              o_mem_rden,
   output logic [2:0]        o_mem_funct3,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata,
   output logic              o_rsp_valid,
   output logic              o_rsp_err,
   output logic [31:0]       o_rsp_rdata
);

   // ---------------------------------------------------------------------------
   // State and registered request
   // ---------------------------------------------------------------------------
   lsu_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic [31:0]       wdata_q;
   logic [31:0]       lo_q;
   logic              split_q;      // load needs the LD_HI word
   logic [1:0]        byte_cnt_q;   // index of the byte store on the port now
   logic [1:0]        last_byte_q;  // N-1 for split stores, 0 otherwise

   // Registered outputs
   mem_cmd_t          mem_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [31:0]       rsp_rdata_q;
   logic              req_ready_q;

   // ---------------------------------------------------------------------------
   // Request decode (evaluated in IDLE on the incoming request)
   // ---------------------------------------------------------------------------
   logic req_is_ld;
   logic req_is_st;
   logic req_mis;
   logic ld_f3_ok;
   logic st_f3_ok;
   logic req_err;

   assign req_is_ld = i_req_rden & ~i_req_wren;
   assign req_is_st = i_req_wren & ~i_req_rden;
   assign req_mis   = is_misaligned(i_req_addr[1:0], i_req_funct3);
   assign ld_f3_ok  = i_req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   assign st_f3_ok  = i_req_funct3 inside {F3_SB, F3_SH, F3_SW};

   // Both or neither strobe fall out of req_is_ld/req_is_st being false.
   assign req_err   = ~((req_is_ld & ld_f3_ok) | (req_is_st & st_f3_ok))
                    | (req_mis & ~MISALIGN_EN);

   // ---------------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0] req_word_addr;
   logic [ADDR_W-1:0] word_addr;
   logic [1:0]        byte_nxt;
   logic [31:0]       extract_lo;
   logic [31:0]       load_result;

   assign req_word_addr = {i_req_addr[ADDR_W-1:2], 2'b00};
   assign word_addr     = {addr_q[ADDR_W-1:2], 2'b00};
   assign byte_nxt      = byte_cnt_q + 2'd1;

   // In LD_LO the live read data is the low word; in LD_HI it is the high
   // word and the low word comes from lo_q. For a non-spanning load the hi
   // input carries don't-care data that the shift never selects.
   assign extract_lo = (state_q == S_LD_HI) ? lo_q : i_mem_rdata;

   lsu_load_extract u_extract (
      .lo_i     (extract_lo),
      .hi_i     (i_mem_rdata),
      .offset_i (addr_q[1:0]),
      .funct3_i (f3_q),
      .result_o (load_result)
   );

   // ---------------------------------------------------------------------------
   // Sequencer. Memory-port outputs are registered: the command for cycle T+1
   // is loaded on the edge that accepts the request at T, and cleared on the
   // edge that enters RESP so the port is quiet in RESP and IDLE.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   // NOTE: all registers here are control/datapath flops and take the async
   // reset; a reset mid-operation simply abandons the sequence.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         f3_q        <= '0;
         wdata_q     <= '0;
         lo_q        <= '0;
         split_q     <= 1'b0;
         byte_cnt_q  <= '0;
         last_byte_q <= '0;
         mem_q       <= '0;
         mem_addr_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         req_ready_q <= 1'b1;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (i_req_valid) begin
                  addr_q      <= i_req_addr;
                  f3_q        <= i_req_funct3;
                  wdata_q     <= i_req_wdata;
                  split_q     <= spans_words(i_req_addr[1:0], i_req_funct3);
                  byte_cnt_q  <= 2'd0;
                  last_byte_q <= 2'd0;
                  req_ready_q <= 1'b0;

                  if (req_err) begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                  end else if (req_is_ld) begin
                     // Loads always read whole aligned words.
                     state_q      <= S_LD_LO;
                     mem_q.en     <= 1'b1;
                     mem_q.rden   <= 1'b1;
                     mem_q.funct3 <= F3_LW;
                     mem_addr_q   <= req_word_addr;
                  end else if (req_mis) begin
                     // First of N byte stores; byte 0 goes to the base address.
                     state_q      <= S_ST;
                     last_byte_q  <= 2'(access_bytes(i_req_funct3) - 3'd1);
                     mem_q.en     <= 1'b1;
                     mem_q.wren   <= 1'b1;
                     mem_q.funct3 <= F3_SB;
                     mem_q.wdata  <= {24'h000000, i_req_wdata[7:0]};
                     mem_addr_q   <= i_req_addr;
                  end else begin
                     state_q      <= S_ST;
                     mem_q.en     <= 1'b1;
                     mem_q.wren   <= 1'b1;
                     mem_q.funct3 <= i_req_funct3;
                     mem_q.wdata  <= i_req_wdata;
                     mem_addr_q   <= i_req_addr;
                  end
               end
            end

            S_LD_LO: begin
               lo_q <= i_mem_rdata;
               if (split_q) begin
                  state_q    <= S_LD_HI;
                  mem_addr_q <= word_addr + ADDR_W'(4);
               end else begin
                  state_q     <= S_RESP;
                  mem_q       <= '0;
                  mem_addr_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= load_result;
               end
            end

            S_LD_HI: begin
               state_q     <= S_RESP;
               mem_q       <= '0;
               mem_addr_q  <= '0;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= load_result;
            end

            S_ST: begin
               if (byte_cnt_q == last_byte_q) begin
                  state_q     <= S_RESP;
                  mem_q       <= '0;
                  mem_addr_q  <= '0;
                  rsp_valid_q <= 1'b1;
               end else begin
                  byte_cnt_q  <= byte_nxt;
                  mem_addr_q  <= addr_q + ADDR_W'(byte_nxt);
                  mem_q.wdata <= {24'h000000, wdata_q[{byte_nxt, 3'b000} +: 8]};
               end
            end

            S_RESP: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end

            default: begin
               state_q     <= S_IDLE;
               mem_q       <= '0;
               mem_addr_q  <= '0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_req_ready  = req_ready_q;
   assign o_mem_en     = mem_q.en;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wren   = mem_q.wren;
   assign o_mem_rden   = mem_q.rden;
   assign o_mem_funct3 = mem_q.funct3;
   assign o_mem_wdata  = mem_q.wdata;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_err    = rsp_err_q;
   assign o_rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_align_seq.sv
// -----------------------------------------------------------------------------
// tb_lsu_align_seq
//   Self-checking bench for lsu_align_seq. A byte-array memory sits on the
//   DUT's memory port; a separate reference byte array plus plain arithmetic
//   on access sizes and offsets predicts response latency, error, the memory
//   access sequence, load data and the final memory image. A second instance
//   with MISALIGN_EN=0 covers misalignment rejection.
// -----------------------------------------------------------------------------
module tb_lsu_align_seq;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic        rd;
      logic [2:0]  f3;
      logic [31:0] wd;
   } acc_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // DUT 1 (MISALIGN_EN = 1)
   logic        req_valid, req_ready, req_wren, req_rden;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_f3;
   logic        mem_en, mem_wren, mem_rden;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_f3;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   // DUT 2 (MISALIGN_EN = 0)
   logic        req_valid2, req_ready2, req_wren2, req_rden2;
   logic [31:0] req_addr2, req_wdata2;
   logic [2:0]  req_f3_2;
   logic        mem_en2, mem_wren2, mem_rden2;
   logic [31:0] mem_addr2, mem_wdata2;
   logic [2:0]  mem_f3_2;
   logic        rsp_valid2, rsp_err2;
   logic [31:0] rsp_rdata2;

   lsu_align_seq #(.MISALIGN_EN(1'b1), .ADDR_W(32)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_addr(req_addr), .i_req_wren(req_wren), .i_req_rden(req_rden),
      .i_req_funct3(req_f3), .i_req_wdata(req_wdata),
      .o_mem_en(mem_en), .o_mem_addr(mem_addr), .o_mem_wren(mem_wren),
      .o_mem_rden(mem_rden), .o_mem_funct3(mem_f3), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata),
      .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata)
   );

   lsu_align_seq #(.MISALIGN_EN(1'b0), .ADDR_W(32)) dut_nomis (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid2), .o_req_ready(req_ready2),
      .i_req_addr(req_addr2), .i_req_wren(req_wren2), .i_req_rden(req_rden2),
      .i_req_funct3(req_f3_2), .i_req_wdata(req_wdata2),
      .o_mem_en(mem_en2), .o_mem_addr(mem_addr2), .o_mem_wren(mem_wren2),
      .o_mem_rden(mem_rden2), .o_mem_funct3(mem_f3_2), .o_mem_wdata(mem_wdata2),
      .i_mem_rdata(32'h0000_0000),
      .o_rsp_valid(rsp_valid2), .o_rsp_err(rsp_err2), .o_rsp_rdata(rsp_rdata2)
   );

   // ---------------------------------------------------------------------------
   // Memory on DUT 1's port: 256 bytes, indexed by address[7:0]
   // ---------------------------------------------------------------------------
   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   logic [7:0] ma;

   assign ma        = mem_addr[7:0];
   assign mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

   always @(posedge clk) begin
      if (mem_en && mem_wren) begin
         mem[ma] = mem_wdata[7:0];
         if (mem_f3 != 3'd0) mem[ma + 8'd1] = mem_wdata[15:8];
         if (mem_f3 == 3'd2) begin
            mem[ma + 8'd2] = mem_wdata[23:16];
            mem[ma + 8'd3] = mem_wdata[31:24];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model helpers
   // ---------------------------------------------------------------------------
   function automatic int ref_size(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic ref_err(input logic wr, input logic rd, input logic [2:0] f3);
      if (wr == rd) return 1'b1;
      if (rd) return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return !(f3 inside {3'd0, 3'd1, 3'd2});
   endfunction

   task automatic mem_set_word(input logic [31:0] a, input logic [31:0] v);
      for (int k = 0; k < 4; k++) begin
         mem[8'(a + 32'(k))]     = v[8*k +: 8];
         ref_mem[8'(a + 32'(k))] = v[8*k +: 8];
      end
   endtask

   // Issue one request on DUT 1, collect its memory accesses and response,
   // and compare against the reference model. Returns the observed rdata.
   task automatic run_and_check(input string name, input logic [31:0] a, input logic wr,
                                input logic rd, input logic [2:0] f3,
                                input logic [31:0] wd, output logic [31:0] rdata);
      acc_t        exp_q[$];
      acc_t        got_q[$];
      acc_t        ac;
      int          size;
      int          off;
      int          exp_lat;
      int          lat;
      int          nbad;
      logic        e;
      logic        err_s;
      logic [31:0] exp_rd;

      size   = ref_size(f3);
      off    = int'(a[1:0]);
      e      = ref_err(wr, rd, f3);
      exp_rd = 32'h0;

      if (!e && rd) begin
         ac = '{addr: a & ~32'd3, wr: 1'b0, rd: 1'b1, f3: 3'd2, wd: 32'h0};
         exp_q.push_back(ac);
         if (off + size > 4) begin
            ac.addr = (a & ~32'd3) + 32'd4;
            exp_q.push_back(ac);
         end
         for (int k = 0; k < size; k++)
            exp_rd |= 32'(ref_mem[8'(a + 32'(k))]) << (8 * k);
         if (!f3[2] && size < 4 && exp_rd[8*size-1])
            exp_rd |= 32'hFFFF_FFFF << (8 * size);
      end else if (!e && wr) begin
         if (int'(a % 32'(size)) == 0) begin
            ac = '{addr: a, wr: 1'b1, rd: 1'b0, f3: f3, wd: wd};
            exp_q.push_back(ac);
         end else begin
            for (int k = 0; k < size; k++) begin
               ac = '{addr: a + 32'(k), wr: 1'b1, rd: 1'b0, f3: 3'd0,
                      wd: {24'h0, wd[8*k +: 8]}};
               exp_q.push_back(ac);
            end
         end
         for (int k = 0; k < size; k++) ref_mem[8'(a + 32'(k))] = wd[8*k +: 8];
      end
      // Every access takes one cycle, then one cycle to respond.
      exp_lat = exp_q.size() + 1;

      @(posedge clk); #1;
      check({name, "_ready"}, {31'h0, req_ready}, 32'd1);
      req_valid = 1'b1; req_addr = a; req_wren = wr; req_rden = rd;
      req_f3 = f3; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom();
      req_wdata = $urandom();

      lat = -1; err_s = 1'b0; rdata = 32'h0;
      for (int k = 1; k <= 12; k++) begin
         if (mem_en) begin
            ac = '{addr: mem_addr, wr: mem_wren, rd: mem_rden, f3: mem_f3,
                   wd: mem_rden ? 32'h0 : mem_wdata};
            got_q.push_back(ac);
         end
         if (rsp_valid) begin
            lat = k; err_s = rsp_err; rdata = rsp_rdata;
            break;
         end
         @(posedge clk); #1;
      end

      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_err"}, {31'h0, err_s}, {31'h0, e});
      if (lat > 0) check({name, "_ready_in_resp"}, {31'h0, req_ready}, 32'd0);
      check({name, "_acc_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
      nbad = 0;
      if (got_q.size() == exp_q.size()) begin
         foreach (exp_q[i])
            if (got_q[i] != exp_q[i]) begin
               nbad++;
               $display("  access %0d: got a=%0h w=%0b r=%0b f3=%0d wd=%0h exp a=%0h w=%0b r=%0b f3=%0d wd=%0h",
                        i, got_q[i].addr, got_q[i].wr, got_q[i].rd, got_q[i].f3, got_q[i].wd,
                        exp_q[i].addr, exp_q[i].wr, exp_q[i].rd, exp_q[i].f3, exp_q[i].wd);
            end
         check({name, "_acc_fields"}, 32'(nbad), 32'd0);
      end
      if (rd && !e) check({name, "_rdata"}, rdata, exp_rd);
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [31:0] rd_v;
      logic [31:0] a;
      logic [2:0]  f3;
      logic        wr, rd;
      int          diffs;
      int          r;

      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_wren = 1'b0; req_rden = 1'b0;
      req_f3 = '0; req_wdata = '0;
      req_valid2 = 1'b0; req_addr2 = '0; req_wren2 = 1'b0; req_rden2 = 1'b0;
      req_f3_2 = '0; req_wdata2 = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00; ref_mem[i] = 8'h00;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_en",    {31'h0, mem_en},    32'd0);
      check("rst_mem_wren",  {31'h0, mem_wren},  32'd0);
      check("rst_mem_rden",  {31'h0, mem_rden},  32'd0);
      check("rst_mem_addr",  mem_addr,           32'd0);
      check("rst_mem_f3",    {29'h0, mem_f3},    32'd0);
      check("rst_mem_wdata", mem_wdata,          32'd0);
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("rst_rsp_err",   {31'h0, rsp_err},   32'd0);
      check("rst_rsp_rdata", rsp_rdata,          32'd0);
      @(negedge clk) rst = 1'b0;
      #1;
      check("rst_ready_after", {31'h0, req_ready}, 32'd1);

      // Aligned SW then LW
      run_and_check("sw10", 32'h10, 1'b1, 1'b0, 3'd2, 32'hDEAD_BEEF, rd_v);
      run_and_check("lw10", 32'h10, 1'b0, 1'b1, 3'd2, 32'h0, rd_v);
      check("lw10_value", rd_v, 32'hDEAD_BEEF);

      // Spanning halfword loads
      mem_set_word(32'h14, 32'h0000_0080);
      run_and_check("lh13", 32'h13, 1'b0, 1'b1, 3'd1, 32'h0, rd_v);
      check("lh13_value", rd_v, 32'hFFFF_80DE);
      run_and_check("lhu13", 32'h13, 1'b0, 1'b1, 3'd5, 32'h0, rd_v);
      check("lhu13_value", rd_v, 32'h0000_80DE);

      // Byte loads in the top byte of a word
      run_and_check("lb13", 32'h13, 1'b0, 1'b1, 3'd0, 32'h0, rd_v);
      check("lb13_value", rd_v, 32'hFFFF_FFDE);
      run_and_check("lbu13", 32'h13, 1'b0, 1'b1, 3'd4, 32'h0, rd_v);
      check("lbu13_value", rd_v, 32'h0000_00DE);

      // Misaligned SW split into four byte stores
      mem_set_word(32'h20, 32'h0);
      mem_set_word(32'h24, 32'h0);
      run_and_check("sw21", 32'h21, 1'b1, 1'b0, 3'd2, 32'h1122_3344, rd_v);
      run_and_check("lw20", 32'h20, 1'b0, 1'b1, 3'd2, 32'h0, rd_v);
      check("lw20_value", rd_v, 32'h2233_4400);
      run_and_check("lw24", 32'h24, 1'b0, 1'b1, 3'd2, 32'h0, rd_v);
      check("lw24_value", rd_v, 32'h0000_0011);

      // Decode errors
      run_and_check("ld_f3_3", 32'h40, 1'b0, 1'b1, 3'd3, 32'h0, rd_v);
      run_and_check("wr_and_rd", 32'h40, 1'b1, 1'b1, 3'd2, 32'h0, rd_v);
      run_and_check("sw_f3_4", 32'h40, 1'b1, 1'b0, 3'd4, 32'h0, rd_v);

      // Misalignment rejection on the MISALIGN_EN=0 instance
      @(posedge clk); #1;
      check("nomis_ready", {31'h0, req_ready2}, 32'd1);
      req_valid2 = 1'b1; req_addr2 = 32'h02; req_rden2 = 1'b1; req_wren2 = 1'b0;
      req_f3_2 = 3'd2;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      check("nomis_lw02_valid",  {31'h0, rsp_valid2}, 32'd1);
      check("nomis_lw02_err",    {31'h0, rsp_err2},   32'd1);
      check("nomis_lw02_mem_en", {31'h0, mem_en2},    32'd0);
      @(posedge clk); #1;
      req_valid2 = 1'b1; req_addr2 = 32'h04;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      check("nomis_lw04_mem", {mem_en2, mem_rden2, mem_wren2, mem_f3_2, 26'h0},
            {1'b1, 1'b1, 1'b0, 3'd2, 26'h0});
      check("nomis_lw04_addr",  mem_addr2,  32'h04);
      check("nomis_lw04_wdata", mem_wdata2, 32'h0);
      check("nomis_lw04_early", {31'h0, rsp_valid2}, 32'd0);
      @(posedge clk); #1;
      check("nomis_lw04_rsp", {30'h0, rsp_valid2, rsp_err2}, 32'b10);
      check("nomis_lw04_rdata", rsp_rdata2, 32'h0);

      // Reset during the third byte store of SW 0x21
      mem_set_word(32'h20, 32'h0);
      mem_set_word(32'h24, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'h21; req_wren = 1'b1; req_rden = 1'b0;
      req_f3 = 3'd2; req_wdata = 32'h1122_3344;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_third_addr",  mem_addr,  32'h23);
      check("abort_third_wdata", mem_wdata, 32'h22);
      rst = 1'b1;
      #1;
      check("abort_mem_en",    {31'h0, mem_en},    32'd0);
      check("abort_mem_wren",  {31'h0, mem_wren},  32'd0);
      check("abort_mem_addr",  mem_addr,           32'd0);
      check("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      @(negedge clk) rst = 1'b0;
      ref_mem[8'h21] = 8'h44;
      ref_mem[8'h22] = 8'h33;
      check("abort_b21", {24'h0, mem[8'h21]}, 32'h44);
      check("abort_b22", {24'h0, mem[8'h22]}, 32'h33);
      check("abort_b23", {24'h0, mem[8'h23]}, 32'h00);
      check("abort_b24", {24'h0, mem[8'h24]}, 32'h00);
      run_and_check("post_abort_lw20", 32'h20, 1'b0, 1'b1, 3'd2, 32'h0, rd_v);
      check("post_abort_lw20_value", rd_v, 32'h0033_4400);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 19);
         a = $urandom();
         if (n % 7 == 0) a = 32'hFFFF_FFFC | (a & 32'd3);
         if (r < 9) begin
            wr = 1'b0; rd = 1'b1;
            case ($urandom_range(0, 4))
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end else if (r < 18) begin
            wr = 1'b1; rd = 1'b0; f3 = 3'($urandom_range(0, 2));
         end else if (r == 18) begin
            rd = 1'($urandom_range(0, 1)); wr = ~rd;
            f3 = rd ? (($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(6, 7)))
                    : 3'($urandom_range(3, 7));
         end else begin
            wr = 1'($urandom_range(0, 1)); rd = wr;
            f3 = 3'($urandom_range(0, 2));
         end
         run_and_check("rnd", a, wr, rd, f3, $urandom(), rd_v);
      end

      diffs = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) diffs++;
      check("mem_image_diffs", 32'(diffs), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_align_seq.md
Name: lsu_align_seq

Overview:
- Sequencer directly upstream of the data memory in the MA stage. Accepts one load/store request at a time from the pipeline and drives the memory port.
- Aligned accesses map to one memory access. Misaligned accesses are split: loads become two aligned word reads that are merged; stores become byte stores.
- Returns a single-cycle response pulse with load data, or an error.

Parameters:
- MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = flag them as error with no memory access
- ADDR_W, 32, address width; word+1 address wraps modulo 2^ADDR_W

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE
- i_req_addr  in  ADDR_W  byte address
- i_req_wren  in  1  store request
- i_req_rden  in  1  load request
- i_req_funct3  in  3  RV32I load/store funct3
- i_req_wdata  in  32  store data
- o_mem_en  out  1  drives memory buffer enable; high in any access cycle
- o_mem_addr  out  ADDR_W  memory byte address
- o_mem_wren  out  1  memory write strobe
- o_mem_rden  out  1  memory read strobe
- o_mem_funct3  out  3  memory access size
- o_mem_wdata  out  32  memory write data, byte in [7:0] for byte stores
- i_mem_rdata  in  32  combinational memory read data
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_err  out  1  qualifies o_rsp_valid
- o_rsp_rdata  out  32  load result, held until the next response

Behaviour:
- Reset (async): state=IDLE. All o_mem_* = 0, o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0, o_req_ready = 1 after deassert.
- Reset mid-operation aborts immediately. Bytes already written stay in memory; there is no rollback.
- States: IDLE, LD_LO, LD_HI, ST, RESP.
- Accept on i_req_valid & o_req_ready at cycle T. Address, funct3 and wdata are registered.
- wren and rden both set, or neither set: error.
- Decode errors:
  - Load funct3 not in {0,1,2,4,5}: error.
  - Store funct3 not in {0,1,2}: error.
  - Misaligned with MISALIGN_EN=0: error.
  - On error: IDLE->RESP, o_rsp_valid and o_rsp_err at T+1, no memory access.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- Loads:
  - Always issued as word reads (funct3=2) at addr&~3.
  - LD_LO at T+1 captures i_mem_rdata.
  - If the access spans words, LD_HI at T+2 reads (addr&~3)+4.
  - Merge: form a 64-bit {hi,lo}, shift right by 8*addr[1:0], take [7:0], [15:0] or [31:0].
  - Sign-extend for funct3 0/1; zero-extend for 4/5.
  - Response at T+2 if aligned, T+3 if split.
- Stores:
  - Aligned: a single ST cycle at T+1 with original funct3, address and wdata; response at T+2.
  - Misaligned: N byte stores (N=2 half, N=4 word) in consecutive ST cycles T+1..T+N.
  - Byte k goes to addr+k with wdata[8k+7:8k].
  - Byte counter width 2; response at T+N+1.
- RESP: o_rsp_valid=1 for one cycle, then IDLE. o_req_ready is 0 in RESP, so the next accept is no earlier than the response cycle+1.
- o_mem_* are zero in IDLE and RESP.
- The responder has no backpressure.

Decomposition:
- Package lsu_pkg:
  - state enum
  - funct3 constants F3_LB/LH/LW/LBU/LHU and F3_SB/SH/SW
  - is_misaligned function
- Sub-module lsu_load_extract (combinational): inputs lo, hi, offset, funct3; output the extended 32-bit result.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10: store rsp at T+2, one write with funct3=2. Load rsp at T+2 with rdata 0xDEADBEEF, no error.
- Preload word 0x10=0xDEADBEEF, 0x14=0x00000080. LH 0x13: LD_LO/LD_HI reads of 0x10/0x14, rsp at T+3, rdata 0xFFFF80DE. LHU 0x13 -> 0x000080DE.
- SW addr 0x21 wdata 0x11223344: byte stores 0x44@0x21, 0x33@0x22, 0x22@0x23, 0x11@0x24 on T+1..T+4, rsp at T+5. LW 0x20 -> 0x22334400; LW 0x24 -> 0x00000011.
- LB 0x13 with word 0x10=0xDEADBEEF -> 0xFFFFFFDE; LBU -> 0x000000DE; single read, rsp at T+2.
- Load funct3=3, and separately wren=rden=1: rsp_valid and rsp_err at T+1, o_mem_en never high. With MISALIGN_EN=0, LW 0x02 -> err at T+1.
- Assert i_rst during the third byte store of SW 0x21: outputs zero at once, state IDLE. Bytes 0x21/0x22 keep their values and 0x24 is unchanged. The next request is accepted normally.
